throw_power_meter: RTL and testbench
====================================

THROW_POWER_METER -- requirements
Module: throw_power_meter

Interface
REQ-001 Parameters SHALL be: STEP_DIV, 650000, clk cycles per power step (100 steps/s at 65 MHz); MAX_POWER, 100, power ceiling (1..127); ARM_TIMEOUT, 1024, cycles ARMED waits for throw_enable.
REQ-002 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-003 clk  input  1  system clock, 65 MHz.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 whose_turn  input  1  local player's turn; low forces abort.
REQ-006 enable_draw  input  1  level from upstream turn FSM; high while space is held.
REQ-007 throw_enable  input  1  level from upstream turn FSM; high during the throw window.
REQ-008 power  output  7  live meter value for the HUD bar.
REQ-009 charging  output  1  high while in CHARGE.
REQ-010 launch  output  1  one-cycle pulse starting the projectile.
REQ-011 launch_power  output  7  power captured at the last launch; held until the next launch.

Function
REQ-012 States SHALL be IDLE, CHARGE, ARMED, LAUNCH, COOLDOWN; all outputs registered.
REQ-013 IDLE: power=0, step divider=0; enable_draw=1 -> CHARGE next cycle.
REQ-014 CHARGE: divider counts 0..STEP_DIV-1; at STEP_DIV-1 it wraps to 0 and power steps by 1 in the same cycle.
REQ-015 CHARGE: enable_draw=0 -> ARMED; power frozen from that edge; a step coinciding with the falling edge is discarded.
REQ-016 ARMED: throw_enable=1 -> LAUNCH; otherwise the timeout counter increments; at ARM_TIMEOUT-1 -> IDLE without launch.
REQ-017 LAUNCH lasts exactly one cycle: launch=1, launch_power<=power -> COOLDOWN.
REQ-018 COOLDOWN: launch=0, power holds; throw_enable=0 -> IDLE (power cleared on IDLE entry).
REQ-019 whose_turn=0 in any state -> IDLE next cycle: power=0, counters=0, charging=0, launch=0; launch_power unchanged; whose_turn=0 overrides all other inputs.
REQ-020 A launch pulse SHALL occur at most once per CHARGE entry.
REQ-021 enable_draw=1 while in ARMED/COOLDOWN SHALL be ignored; a new charge starts only from IDLE.
REQ-022 power SHALL never exceed MAX_POWER nor underflow below 0; arithmetic in 7 bits, divider 20 bits, timeout counter 11 bits.

Reset
REQ-023 rst=1 -> state IDLE, power=0, launch_power=0, charging=0, launch=0, divider=0, timeout=0, direction=up, on the next clk edge.
REQ-024 rst mid-charge or mid-launch SHALL suppress any pending launch pulse.

Configuration
REQ-025 Macro POWER_PINGPONG_EN defined: power ramps up to MAX_POWER, then down to 0, then up again, repeating while charging; the direction bit resets to up on each CHARGE entry.
REQ-026 POWER_PINGPONG_EN undefined: power saturates at MAX_POWER and holds; the direction logic is absent.

Verification (STEP_DIV=4, MAX_POWER=10, ARM_TIMEOUT=8)
REQ-027 enable_draw high 20 cycles, then low with throw_enable high -> power=5 at release; one launch pulse; launch_power=5.
REQ-028 enable_draw held 100 cycles, POWER_PINGPONG_EN undefined -> power stops at 10; launch_power=10.
REQ-029 enable_draw held 60 cycles, POWER_PINGPONG_EN defined -> power 0->10->5 (15 steps); launch_power=5.
REQ-030 Charge to 3, release, throw_enable never asserted -> IDLE after 8 cycles in ARMED; no launch; launch_power keeps its prior value.
REQ-031 whose_turn dropped during CHARGE at power=4 -> next cycle power=0, charging=0, no launch; a subsequent throw_enable pulse produces no launch.
REQ-032 rst asserted during COOLDOWN after launch_power=7 -> launch_power=0, state IDLE, launch=0.

Source files
------------

// File: rtl/throw_power_meter.sv
// throw_power_meter: charge-and-release power meter for a turn-based throw.
// Optional build macro POWER_PINGPONG_EN: power bounces 0..MAX_POWER..0 while
// charging instead of saturating at MAX_POWER.
module throw_power_meter #(
    parameter int STEP_DIV    = 650000,
    parameter int MAX_POWER   = 100,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       whose_turn,
    input  logic       enable_draw,
    input  logic       throw_enable,
    output logic [6:0] power,
    output logic       charging,
    output logic       launch,
    output logic [6:0] launch_power
);
    typedef enum logic [2:0] {IDLE, CHARGE, ARMED, LAUNCH, COOLDOWN} state_t;

    localparam logic [19:0] DIV_LAST = 20'(STEP_DIV - 1);
    localparam logic [10:0] TO_LAST  = 11'(ARM_TIMEOUT - 1);
    localparam logic [6:0]  MAX_P    = 7'(MAX_POWER);

    state_t      state;
    logic [19:0] div;
    logic [10:0] timeout;
    logic [6:0]  step_power;
`ifdef POWER_PINGPONG_EN
    logic        dir_down;
    logic        step_down;

    // next power value on a step; direction flips on reaching either end
    always_comb begin
        step_power = dir_down ? power - 7'd1 : power + 7'd1;
        step_down  = dir_down ? (power != 7'd1) : (power == MAX_P - 7'd1);
    end
`else
    // next power value on a step, saturating at the ceiling
    always_comb begin
        step_power = (power == MAX_P) ? power : power + 7'd1;
    end
`endif

    // meter state machine; abort and reset share the return-to-idle path
    always_ff @(posedge clk) begin
        if (rst || !whose_turn) begin
            state        <= IDLE;
            power        <= '0;
            charging     <= 1'b0;
            launch       <= 1'b0;
            div          <= '0;
            timeout      <= '0;
            launch_power <= rst ? 7'd0 : launch_power;
`ifdef POWER_PINGPONG_EN
            dir_down     <= 1'b0;
`endif
        end else begin
            launch <= 1'b0;
            case (state)
                IDLE: begin
                    power   <= '0;
                    div     <= '0;
                    timeout <= '0;
`ifdef POWER_PINGPONG_EN
                    dir_down <= 1'b0;
`endif
                    if (enable_draw) begin
                        state    <= CHARGE;
                        charging <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (!enable_draw) begin
                        state    <= ARMED;
                        charging <= 1'b0;
                        div      <= '0;
                        timeout  <= '0;
                    end else if (div == DIV_LAST) begin
                        div   <= '0;
                        power <= step_power;
`ifdef POWER_PINGPONG_EN
                        dir_down <= step_down;
`endif
                    end else begin
                        div <= div + 20'd1;
                    end
                end
                ARMED: begin
                    if (throw_enable) begin
                        state        <= LAUNCH;
                        launch       <= 1'b1;
                        launch_power <= power;
                        timeout      <= '0;
                    end else if (timeout == TO_LAST) begin
                        state   <= IDLE;
                        power   <= '0;
                        timeout <= '0;
                    end else begin
                        timeout <= timeout + 11'd1;
                    end
                end
                LAUNCH: state <= COOLDOWN;
                COOLDOWN: begin
                    if (!throw_enable) begin
                        state <= IDLE;
                        power <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_throw_power_meter.sv
// tb_throw_power_meter: directed and randomized throws against an arithmetic power model.
module tb_throw_power_meter;
    localparam int SD = 4, MX = 10, AT = 8;

    logic       clk = 1'b0, rst = 1'b1, whose_turn = 1'b1, enable_draw = 1'b0, throw_enable = 1'b0;
    logic [6:0] power, launch_power;
    logic       charging, launch;
    int         checks = 0, errors = 0, lp_model = 0;

    throw_power_meter #(.STEP_DIV(SD), .MAX_POWER(MX), .ARM_TIMEOUT(AT)) dut (
        .clk(clk), .rst(rst), .whose_turn(whose_turn), .enable_draw(enable_draw),
        .throw_enable(throw_enable), .power(power), .charging(charging),
        .launch(launch), .launch_power(launch_power)
    );

    always #5 clk = ~clk;

    // expected power after k cycles spent charging
    function automatic int f(input int k);
        int s, r;
        s = k / SD;
        r = s % (2 * MX);
`ifdef POWER_PINGPONG_EN
        return (r <= MX) ? r : 2 * MX - r;
`else
        r = 0;
        return (s < MX) ? s + r : MX;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one complete throw: h charging cycles, w idle cycles in ARMED, optional reset in cooldown
    task automatic run_throw(input int h, input int w, input bit rst_cool);
        int p;
        enable_draw = 1'b1;
        throw_enable = 1'b0;
        tick();
        chk("entry_charging", charging, 1);
        chk("entry_power", power, 0);
        for (int k = 1; k <= h; k++) begin
            tick();
            chk("ramp_power", power, f(k));
            chk("ramp_charging", charging, 1);
            chk("ramp_launch", launch, 0);
        end
        p = f(h);
        enable_draw = 1'b0;
        tick();
        chk("armed_power", power, p);
        chk("armed_charging", charging, 0);
        for (int j = 1; j <= w && j <= AT; j++) begin
            enable_draw = 1'($urandom % 2);
            tick();
            chk("armed_launch", launch, 0);
            chk("armed_hold", power, (j == AT) ? 0 : p);
        end
        enable_draw = 1'b0;
        if (w >= AT) begin
            chk("timeout_lp", launch_power, lp_model);
            tick();
            chk("timeout_idle_power", power, 0);
            chk("timeout_idle_charging", charging, 0);
            return;
        end
        throw_enable = 1'b1;
        enable_draw = 1'($urandom % 2);
        tick();
        chk("launch_pulse", launch, 1);
        chk("launch_power", launch_power, p);
        lp_model = p;
        tick();
        chk("launch_once", launch, 0);
        chk("cool_power", power, p);
        enable_draw = 1'b0;
        if (rst_cool) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            lp_model = 0;
            chk("rst_cool_lp", launch_power, 0);
            chk("rst_cool_launch", launch, 0);
            chk("rst_cool_power", power, 0);
            throw_enable = 1'b0;
            return;
        end
        throw_enable = 1'b0;
        tick();
        chk("idle_power", power, 0);
        chk("idle_launch", launch, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_power", power, 0);
        chk("reset_lp", launch_power, 0);
        chk("reset_charging", charging, 0);
        chk("reset_launch", launch, 0);
        tick();
        chk("idle_no_draw", charging, 0);

        run_throw(20, 0, 1'b0);
        chk("req027_lp", launch_power, 5);
        run_throw(100, 1, 1'b0);
`ifdef POWER_PINGPONG_EN
        chk("req028_lp", launch_power, 5);
        run_throw(60, 0, 1'b0);
        chk("req029_lp", launch_power, 5);
`else
        chk("req028_lp", launch_power, 10);
`endif
        run_throw(12, AT + 3, 1'b0);
        chk("req030_lp_kept", launch_power, lp_model);

        // abort mid-charge at power 4
        enable_draw = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) tick();
        chk("abort_pre_power", power, 4);
        whose_turn = 1'b0;
        tick();
        chk("abort_power", power, 0);
        chk("abort_charging", charging, 0);
        chk("abort_launch", launch, 0);
        whose_turn = 1'b1;
        enable_draw = 1'b0;
        throw_enable = 1'b1;
        tick();
        chk("abort_no_launch1", launch, 0);
        tick();
        chk("abort_no_launch2", launch, 0);
        chk("abort_lp_kept", launch_power, lp_model);
        throw_enable = 1'b0;
        tick();

        run_throw(28, 2, 1'b1);

        // reset mid-charge suppresses any launch
        run_throw(8, 0, 1'b0);
        enable_draw = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        enable_draw = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_chg_power", power, 0);
        chk("rst_chg_lp", launch_power, 0);
        lp_model = 0;
        throw_enable = 1'b1;
        tick();
        chk("rst_chg_no_launch1", launch, 0);
        tick();
        chk("rst_chg_no_launch2", launch, 0);
        throw_enable = 1'b0;
        tick();

        for (int i = 0; i < 25; i++) begin
            run_throw(int'($urandom_range(0, 60)), int'($urandom_range(0, 10)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
